// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle,
// followed by a single sign-fixup cycle that writes HI/LO and pulses done.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // acc: product upper half / partial remainder
  logic [WIDTH-1:0]  acc_q, acc_d;
  // mq: multiplier shifting out, product lower half shifting in / dividend -> quotient
  logic [WIDTH-1:0]  mq_q, mq_d;
  // mcand: multiplicand or divisor magnitude
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  // Raw a kept so a divide by zero can return it untouched in HI
  logic [WIDTH-1:0]  araw_q, araw_d;
  logic              bzero_q, bzero_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div0_q, div0_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              is_signed;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    msum;
  logic [WIDTH:0]    dshift;
  logic [WIDTH-1:0]  ddiff;
  logic              dge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  quot, rem;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      araw_q  <= '0;
      bzero_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      araw_q  <= araw_d;
      bzero_q <= bzero_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand magnitudes and per-iteration datapath for both algorithms
  always_comb begin
    is_signed = ~op[0];
    abs_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    msum      = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    dshift    = {acc_q, mq_q[WIDTH-1]};
    dge       = dshift >= {1'b0, mcand_q};
    // Difference is below the divisor whenever it is kept, so WIDTH bits suffice
    ddiff     = dshift[WIDTH-1:0] - mcand_q;
    prod      = neg_q ? (~{acc_q, mq_q} + 1'b1) : {acc_q, mq_q};
    quot      = neg_q ? (~mq_q + 1'b1) : mq_q;
    rem       = rneg_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Next-state logic: accept work in idle, iterate in run, fix signs and commit in fix
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    araw_d  = araw_q;
    bzero_d = bzero_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = StRun;
          op_d    = op;
          cnt_d   = CntW'(WIDTH - 1);
          acc_d   = '0;
          araw_d  = a;
          bzero_d = (b == '0);
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = is_signed & a[WIDTH-1];
          busy_d  = 1'b1;
          div0_d  = 1'b0;
          if (op[1]) begin
            mq_d    = abs_a;
            mcand_d = abs_b;
          end else begin
            mq_d    = abs_b;
            mcand_d = abs_a;
          end
        end
      end
      StRun: begin
        if (op_q[1]) begin
          acc_d = dge ? ddiff : dshift[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], dge};
        end else begin
          acc_d = msum[WIDTH:1];
          mq_d  = {msum[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (bzero_q) begin
          hi_d   = araw_q;
          lo_d   = '1;
          div0_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the core ALU in the execute stage of the MIPS datapath. It executes MULT, MULTU, DIV and DIVU over multiple cycles using radix-2 shift-add multiply and restoring divide. A start/busy/done handshake lets the controller stall while the unit runs. It also supports direct MTHI/MTLO writes when idle.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  data for hi_we / lo_we
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi/lo hold new result
- div0  out  1  last completed divide had b == 0
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

## Operation
- States: IDLE, RUN, FIX.
  - IDLE → RUN when start = 1: latch op; store |a| and |b| for the signed ops, raw values for the unsigned ops; record the result sign(s); load counter = WIDTH-1; clear div0.
  - RUN → RUN while counter ≠ 0: one iteration per cycle; counter decrements.
  - RUN → FIX when counter == 0 and the final iteration completes.
  - FIX → IDLE unconditionally: apply sign correction, write hi/lo, pulse done.
- Multiply iterations: {acc, multiplier} shift-right; add the multiplicand into acc when multiplier LSB = 1. Uses a WIDTH+1 bit adder for the carry.
- Divide iterations: shift {rem, quot} left; trial-subtract the divisor; keep the difference and set the quotient bit when the difference is non-negative.
- Signed results:
  - Product is negated (2·WIDTH bits) if sign(a) ≠ sign(b).
  - Quotient is negated if sign(a) ≠ sign(b), truncating toward zero.
  - Remainder takes the sign of a.
- Most-negative / -1 wraps: lo = most-negative value, hi = 0.
- Divide by zero (b == 0, DIV or DIVU):
  - Full latency still applies.
  - Result is hi = a as presented, lo = all ones, div0 = 1.
  - div0 holds until the next accepted start.
- MTHI/MTLO:
  - In IDLE, hi_we / lo_we write wdata at the clock edge; both may fire together.
  - Outside IDLE both strobes are ignored.
- start outside IDLE is ignored; no queueing.
- start and hi_we/lo_we in the same IDLE cycle: both take effect; the operation result later overwrites hi/lo.
- hi/lo change only on a FIX edge or an accepted MTHI/MTLO write.

## Timing
- Reset values: state IDLE, busy 0, done 0, div0 0, hi 0, lo 0, counter 0.
- Reset asserted mid-operation aborts the operation with the same values. No done pulse follows.
- start sampled at edge k:
  - busy = 1 from after edge k through edge k+WIDTH+1.
  - RUN occupies edges k+1 … k+WIDTH.
  - FIX edge k+WIDTH+1: hi, lo, div0 update; done = 1 and busy = 0 for exactly that one cycle.
- Latency is WIDTH+1 cycles from the start edge to the done cycle; for WIDTH=32, done is seen in cycle 34 counting the start cycle as 1.
- done cycle is IDLE, so a new start there is accepted (back-to-back operations, no bubble).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly WIDTH+1 cycles after the start edge; busy high for WIDTH+1 cycles.
- MULT a=-3, b=7, then back-to-back MULT a=0x80000000, b=0x80000000 -> first result hi=0xFFFFFFFF, lo=0xFFFFFFEB; second hi=0x40000000, lo=0x00000000; second start issued in the first done cycle.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, div0=1. Then MULTU 2×3: div0 clears on start; result lo=6.
- start pulse and hi_we (wdata=0x1234) issued while busy -> both ignored; the original result is unchanged. In IDLE, hi_we + lo_we with wdata=0xABCD -> hi=lo=0xABCD next cycle.
- reset asserted 10 cycles into a MULTU -> busy, done, hi, lo all 0 immediately; no done pulse afterward; a subsequent MULTU 5×6 gives lo=30.
